// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP controller with IR, BYPASS, IDCODE,
// internal boundary-scan and USER data registers.
module jtag_tap_param #(
    parameter int                  IR_WIDTH   = 4,
    parameter int                  BSR_LEN    = 8,
    parameter int                  USER_WIDTH = 8,
    parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] OP_EXTEST  = 'h0,
    parameter logic [IR_WIDTH-1:0] OP_IDCODE  = 'h1,
    parameter logic [IR_WIDTH-1:0] OP_SAMPLE  = 'h2,
    parameter logic [IR_WIDTH-1:0] OP_USER    = 'h8
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    input  logic [BSR_LEN-1:0]    pins_in,
    output logic [BSR_LEN-1:0]    pins_out,
    output logic                  bsr_mode,
    input  logic [USER_WIDTH-1:0] user_in,
    output logic [USER_WIDTH-1:0] user_out,
    output logic                  user_upd,
    output logic [3:0]            tap_state,
    output logic [IR_WIDTH-1:0]   instr
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    tap_state_t state_q;
    tap_state_t state_d;

    logic cap_dr;
    logic sh_dr;
    logic upd_dr;
    logic cap_ir;
    logic sh_ir;
    logic upd_ir;
    logic enter_tlr;

    logic [IR_WIDTH-1:0]   ir_sr;
    logic [IR_WIDTH-1:0]   instr_q;
    logic [31:0]           id_sr;
    logic [BSR_LEN-1:0]    bsr_sr;
    logic [BSR_LEN-1:0]    bsr_upd;
    logic [USER_WIDTH-1:0] user_sr;
    logic                  byp_sr;

    logic ir_ones;
    logic sel_id;
    logic sel_bsr;
    logic sel_user;
    logic sel_byp;
    logic dr_lsb;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_dr  = 1'b0;
        sh_dr   = 1'b0;
        upd_dr  = 1'b0;
        cap_ir  = 1'b0;
        sh_ir   = 1'b0;
        upd_ir  = 1'b0;
        unique case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: begin
                cap_dr  = 1'b1;
                state_d = tms ? EX1_DR : SH_DR;
            end
            SH_DR: begin
                sh_dr   = 1'b1;
                state_d = tms ? EX1_DR : SH_DR;
            end
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: begin
                upd_dr  = 1'b1;
                state_d = tms ? SEL_DR : RTI;
            end
            SEL_IR: state_d = tms ? TLR : CAP_IR;
            CAP_IR: begin
                cap_ir  = 1'b1;
                state_d = tms ? EX1_IR : SH_IR;
            end
            SH_IR: begin
                sh_ir   = 1'b1;
                state_d = tms ? EX1_IR : SH_IR;
            end
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: begin
                upd_ir  = 1'b1;
                state_d = tms ? SEL_DR : RTI;
            end
            default: state_d = TLR;
        endcase
    end

    // Registers take their reset values on the edge that lands in TLR.
    assign enter_tlr = (state_d == TLR);

    // All-ones always decodes to BYPASS, even if an opcode parameter collides.
    assign ir_ones  = &instr_q;
    assign sel_id   = !ir_ones && (instr_q == OP_IDCODE);
    assign sel_bsr  = !ir_ones && !sel_id &&
                      ((instr_q == OP_SAMPLE) || (instr_q == OP_EXTEST));
    assign sel_user = !ir_ones && !sel_id && !sel_bsr &&
                      (instr_q == OP_USER);
    assign sel_byp  = !(sel_id || sel_bsr || sel_user);

    always_comb begin
        dr_lsb = byp_sr;
        unique case (1'b1)
            sel_id:   dr_lsb = id_sr[0];
            sel_bsr:  dr_lsb = bsr_sr[0];
            sel_user: dr_lsb = user_sr[0];
            default:  dr_lsb = byp_sr;
        endcase
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_sr   <= '0;
            instr_q <= OP_IDCODE;
        end else if (enter_tlr) begin
            ir_sr   <= '0;
            instr_q <= OP_IDCODE;
        end else begin
            if (cap_ir) begin
                ir_sr <= IR_WIDTH'(2'b01);
            end else if (sh_ir) begin
                ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            end
            if (upd_ir) begin
                instr_q <= ir_sr;
            end
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            id_sr   <= '0;
            bsr_sr  <= '0;
            user_sr <= '0;
            byp_sr  <= 1'b0;
        end else if (cap_dr) begin
            unique case (1'b1)
                sel_id:   id_sr   <= IDCODE_VAL;
                sel_bsr:  bsr_sr  <= pins_in;
                sel_user: user_sr <= user_in;
                default:  byp_sr  <= 1'b0;
            endcase
        end else if (sh_dr) begin
            unique case (1'b1)
                sel_id:   id_sr <= {tdi, id_sr[31:1]};
                sel_bsr:  bsr_sr <= (bsr_sr >> 1) |
                                    (BSR_LEN'(tdi) << (BSR_LEN - 1));
                sel_user: user_sr <= (user_sr >> 1) |
                                     (USER_WIDTH'(tdi) << (USER_WIDTH - 1));
                default:  byp_sr <= tdi;
            endcase
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            bsr_upd  <= '0;
            user_out <= '0;
            user_upd <= 1'b0;
        end else if (enter_tlr) begin
            bsr_upd  <= '0;
            user_out <= '0;
            user_upd <= 1'b0;
        end else begin
            user_upd <= upd_dr && sel_user;
            if (upd_dr && sel_bsr) begin
                bsr_upd <= bsr_sr;
            end
            if (upd_dr && sel_user) begin
                user_out <= user_sr;
            end
        end
    end

    // Output side changes on the falling edge so the board samples a stable tdo.
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= (state_q == SH_DR) || (state_q == SH_IR);
            if (state_q == SH_IR) begin
                tdo <= ir_sr[0];
            end else if (state_q == SH_DR) begin
                tdo <= dr_lsb;
            end else begin
                tdo <= 1'b0;
            end
        end
    end

    assign bsr_mode  = !ir_ones && (instr_q == OP_EXTEST);
    assign pins_out  = bsr_mode ? bsr_upd : pins_in;
    assign tap_state = state_q;
    assign instr     = instr_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: FSM walk, IR/DR shifting,
// IDCODE, BYPASS, SAMPLE/EXTEST, USER update and async reset.
module tb_jtag_tap_param;

    logic       tck;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [7:0] pins_in;
    logic [7:0] pins_out;
    logic       bsr_mode;
    logic [7:0] user_in;
    logic [7:0] user_out;
    logic       user_upd;
    logic [3:0] tap_state;
    logic [3:0] instr;

    int n_chk;
    int n_pass;

    logic [63:0] d1;
    logic [63:0] d2;

    jtag_tap_param dut (
        .tck       (tck),
        .trst      (trst),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .pins_in   (pins_in),
        .pins_out  (pins_out),
        .bsr_mode  (bsr_mode),
        .user_in   (user_in),
        .user_out  (user_out),
        .user_upd  (user_upd),
        .tap_state (tap_state),
        .instr     (instr)
    );

    initial tck = 1'b0;
    always #10 tck = ~tck;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One tck cycle; returns just after the falling edge.
    task automatic clk(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // Shift n bits from a Shift state, leaving via Exit1 on the last one.
    task automatic shift_bits(input int n, input logic [63:0] din,
                              output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            clk(i == n - 1, din[i]);
        end
    endtask

    task automatic goto_shdr();
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    task automatic goto_shir();
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    task automatic exit_upd();
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [3:0] v);
        logic [63:0] d;
        goto_shir();
        shift_bits(4, {60'd0, v}, d);
        exit_upd();
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        trst    = 1'b0;
        tms     = 1'b1;
        tdi     = 1'b0;
        pins_in = 8'h5A;
        user_in = 8'h99;
        #2;
        trst = 1'b1;
        #2;
        chk("rst_state", tap_state, 4'hF);
        chk("rst_instr", instr, 4'h1);
        chk("rst_tdo", tdo, 1'b0);
        chk("rst_tdo_en", tdo_en, 1'b0);
        chk("rst_user_out", user_out, 8'h00);
        chk("rst_user_upd", user_upd, 1'b0);
        chk("rst_bsr_mode", bsr_mode, 1'b0);
        chk("rst_pins_out", pins_out, 8'h5A);
        trst = 1'b0;
        clk(1'b0, 1'b0);
        chk("rti_state", tap_state, 4'hC);

        // Five tms=1 from Shift-DR land in TLR and restore IDCODE
        load_ir(4'h8);
        chk("ir_user", instr, 4'h8);
        goto_shdr();
        chk("shdr_state", tap_state, 4'h2);
        chk("shdr_tdo_en", tdo_en, 1'b1);
        for (int i = 0; i < 5; i++) clk(1'b1, 1'b0);
        chk("tms5_state", tap_state, 4'hF);
        chk("tms5_instr", instr, 4'h1);
        chk("tms5_tdo_en", tdo_en, 1'b0);
        chk("tms5_user_out", user_out, 8'h00);
        clk(1'b0, 1'b0);

        // IDCODE straight through
        goto_shdr();
        shift_bits(32, 64'd0, d1);
        chk("idcode", d1[31:0], 32'h1000_0001);
        exit_upd();

        // IDCODE with a pause in the middle
        goto_shdr();
        shift_bits(8, 64'd0, d1);
        chk("ex1dr_state", tap_state, 4'h1);
        clk(1'b0, 1'b0);
        chk("paudr_state", tap_state, 4'h3);
        clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        chk("ex2dr_state", tap_state, 4'h0);
        clk(1'b0, 1'b0);
        shift_bits(24, 64'd0, d2);
        chk("idcode_pause", {d2[23:0], d1[7:0]}, 32'h1000_0001);
        exit_upd();

        // BYPASS: one-cycle delay, captured 0 first
        load_ir(4'hF);
        chk("ir_bypass", instr, 4'hF);
        goto_shdr();
        shift_bits(4, 64'b1101, d1);
        chk("bypass_tdo", d1[3:0], 4'b1010);
        exit_upd();

        // Capture-IR pattern, then an undefined opcode acts as BYPASS
        goto_shir();
        chk("shir_state", tap_state, 4'hA);
        shift_bits(4, 64'h5, d1);
        chk("capir_tdo", d1[3:0], 4'b0001);
        clk(1'b1, 1'b0);
        chk("updir_state", tap_state, 4'hD);
        clk(1'b0, 1'b0);
        chk("ir_5", instr, 4'h5);
        goto_shdr();
        shift_bits(2, 64'b11, d1);
        chk("undef_bypass", d1[1:0], 2'b10);
        exit_upd();

        // SAMPLE/PRELOAD then EXTEST
        load_ir(4'h2);
        goto_shdr();
        shift_bits(8, 64'hA5, d1);
        chk("sample_cap", d1[7:0], 8'h5A);
        exit_upd();
        chk("sample_mode", bsr_mode, 1'b0);
        pins_in = 8'hC3;
        #1;
        chk("sample_pins", pins_out, 8'hC3);
        load_ir(4'h0);
        chk("extest_mode", bsr_mode, 1'b1);
        chk("extest_pins", pins_out, 8'hA5);
        pins_in = 8'h0F;
        #1;
        chk("extest_hold", pins_out, 8'hA5);

        // USER register and its update pulse
        load_ir(4'h8);
        chk("user_mode", bsr_mode, 1'b0);
        chk("user_pins", pins_out, 8'h0F);
        goto_shdr();
        shift_bits(8, 64'h3C, d1);
        chk("user_cap", d1[7:0], 8'h99);
        clk(1'b1, 1'b0);
        chk("upd_pre", user_upd, 1'b0);
        clk(1'b0, 1'b0);
        chk("upd_pulse", user_upd, 1'b1);
        chk("user_out", user_out, 8'h3C);
        clk(1'b0, 1'b0);
        chk("upd_post", user_upd, 1'b0);

        // trst while shifting USER discards everything
        goto_shdr();
        for (int i = 0; i < 3; i++) clk(1'b0, 1'b1);
        trst = 1'b1;
        #2;
        chk("trst_state", tap_state, 4'hF);
        chk("trst_user_out", user_out, 8'h00);
        chk("trst_instr", instr, 4'h1);
        trst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk(1'b1, 1'b0);
            chk("trst_no_upd", user_upd, 1'b0);
        end
        chk("trst_user_keep", user_out, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
